// File: rtl/led_panel_sink_pkg.sv
// Shared definitions for the LED panel drive interface (panel driver and panel-side sink).
package led_panel_sink_pkg;

   localparam int unsigned LED_COLS = 32;
   localparam int unsigned LED_ROWS = 4;

   typedef struct packed {
      logic r;
      logic g;
      logic b;
   } rgb_t;

endpackage

// File: rtl/led_panel_sink_sync_edge.sv
// N-stage input synchroniser with one extra delay flop for rise/fall detection.
module led_panel_sink_sync_edge #(
   parameter int unsigned W      = 1,
   parameter int unsigned STAGES = 2,
   parameter logic [W-1:0] IDLE  = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] lvl_o,
   output logic [W-1:0] rise_o,
   output logic [W-1:0] fall_o
);

   logic [W-1:0] dly_q;

   if (STAGES == 0) begin : g_direct
      assign lvl_o = d_i;
   end else begin : g_sync
      logic [STAGES-1:0][W-1:0] sync_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sync_q <= {STAGES{IDLE}};
         end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
         end
      end

      assign lvl_o = sync_q[STAGES-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dly_q <= IDLE;
      else        dly_q <= lvl_o;
   end

   assign rise_o = lvl_o & ~dly_q;
   assign fall_o = ~lvl_o & dly_q;

endmodule

// File: rtl/led_panel_sink.sv
// Panel-side receiver: oversamples the LED drive bus, deserialises both half-panels
// and stores every latched row in a readable frame store.
module led_panel_sink
   import led_panel_sink_pkg::*;
#(
   parameter int unsigned COLS        = LED_COLS,
   parameter int unsigned ROWS        = LED_ROWS,
   parameter int unsigned SYNC_STAGES = 2,
   localparam int unsigned CW         = $clog2(COLS),
   localparam int unsigned RW         = $clog2(ROWS),
   localparam int unsigned SRW        = $clog2(2*ROWS)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           sclk_in,
   input  logic           red_in,
   input  logic           green_in,
   input  logic           blue_in,
   input  logic           latch_in,
   input  logic           blank_in,
   input  logic           aclk_in,
   input  logic           arst_in,
   input  logic [SRW-1:0] rd_row,
   input  logic [CW-1:0]  rd_col,
   output logic [2:0]     rd_rgb,
   output logic           row_stb,
   output logic [RW-1:0]  row_idx,
   output logic           frame_stb,
   output logic [CW:0]    shift_cnt,
   output logic           len_err,
   output logic           lit
);

   localparam int unsigned NENT     = 2**SRW;
   localparam logic [CW:0] CNT_FULL = (CW+1)'(COLS);
   localparam logic [CW:0] CNT_MAX  = (CW+1)'(COLS+1);
   localparam logic [RW-1:0] ROW_LAST = RW'(ROWS-1);

   logic       sclk_lvl, sclk_rise, sclk_fall;
   logic       latch_lvl, latch_rise, latch_fall;
   logic       aclk_lvl, aclk_rise, aclk_fall;
   logic       arst_lvl, arst_rise, arst_fall;
   logic       blank_lvl, blank_rise, blank_fall;
   logic [2:0] rgb_lvl, rgb_rise, rgb_fall;
   rgb_t       rgb_s;

   led_panel_sink_sync_edge #(.W(1), .STAGES(SYNC_STAGES), .IDLE(1'b1)) u_sclk (
      .clk(clk), .rst_n(reset), .d_i(sclk_in),
      .lvl_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall));

   led_panel_sink_sync_edge #(.W(1), .STAGES(SYNC_STAGES), .IDLE(1'b0)) u_latch (
      .clk(clk), .rst_n(reset), .d_i(latch_in),
      .lvl_o(latch_lvl), .rise_o(latch_rise), .fall_o(latch_fall));

   led_panel_sink_sync_edge #(.W(1), .STAGES(SYNC_STAGES), .IDLE(1'b0)) u_aclk (
      .clk(clk), .rst_n(reset), .d_i(aclk_in),
      .lvl_o(aclk_lvl), .rise_o(aclk_rise), .fall_o(aclk_fall));

   led_panel_sink_sync_edge #(.W(1), .STAGES(SYNC_STAGES), .IDLE(1'b0)) u_arst (
      .clk(clk), .rst_n(reset), .d_i(arst_in),
      .lvl_o(arst_lvl), .rise_o(arst_rise), .fall_o(arst_fall));

   led_panel_sink_sync_edge #(.W(1), .STAGES(SYNC_STAGES), .IDLE(1'b1)) u_blank (
      .clk(clk), .rst_n(reset), .d_i(blank_in),
      .lvl_o(blank_lvl), .rise_o(blank_rise), .fall_o(blank_fall));

   // Data goes through the same depth as sclk so each bit stays aligned with its edge.
   led_panel_sink_sync_edge #(.W(3), .STAGES(SYNC_STAGES), .IDLE(3'b000)) u_rgb (
      .clk(clk), .rst_n(reset), .d_i({red_in, green_in, blue_in}),
      .lvl_o(rgb_lvl), .rise_o(rgb_rise), .fall_o(rgb_fall));

   logic unused_edges;
   assign unused_edges = ^{sclk_lvl, latch_lvl, latch_fall, aclk_lvl, aclk_fall,
                           arst_rise, arst_fall, blank_rise, blank_fall, rgb_rise, rgb_fall};

   assign rgb_s = rgb_t'(rgb_lvl);

   rgb_t [COLS-1:0] lo_q, lo_d, hi_q, hi_d;
   rgb_t [COLS-1:0] store_q [NENT];
   logic [CW:0]     cnt_q, cnt_d;
   logic [RW-1:0]   row_q, row_d, row_idx_q;
   logic            row_stb_q, frame_stb_q, len_err_q;
   logic [2:0]      rd_rgb_q;

   always_comb begin
      lo_d  = lo_q;
      hi_d  = hi_q;
      cnt_d = cnt_q;
      if (sclk_rise) begin
         lo_d = {lo_q[COLS-2:0], rgb_s};
         if (cnt_q != CNT_MAX) cnt_d = cnt_q + (CW+1)'(1);
      end
      if (sclk_fall) hi_d = {hi_q[COLS-2:0], rgb_s};
   end

   always_comb begin
      row_d = row_q;
      if (arst_lvl)       row_d = '0;
      else if (aclk_rise) row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
   end

   // A latch in the same cycle as a shift stores the post-shift chains (lo_d/hi_d),
   // and always uses the pre-advance row address.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lo_q        <= '0;
         hi_q        <= '0;
         cnt_q       <= '0;
         row_q       <= '0;
         row_idx_q   <= '0;
         row_stb_q   <= 1'b0;
         frame_stb_q <= 1'b0;
         len_err_q   <= 1'b0;
         rd_rgb_q    <= '0;
         for (int i = 0; i < NENT; i++) store_q[i] <= '0;
      end else begin
         lo_q        <= lo_d;
         hi_q        <= hi_d;
         row_q       <= row_d;
         row_stb_q   <= latch_rise;
         frame_stb_q <= latch_rise && (row_q == ROW_LAST);
         rd_rgb_q    <= store_q[rd_row][rd_col];
         if (latch_rise) begin
            store_q[{1'b0, row_q}] <= hi_d;
            store_q[{1'b1, row_q}] <= lo_d;
            row_idx_q              <= row_q;
            len_err_q              <= len_err_q | (cnt_d != CNT_FULL);
            cnt_q                  <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end
   end

   assign rd_rgb    = rd_rgb_q;
   assign row_stb   = row_stb_q;
   assign row_idx   = row_idx_q;
   assign frame_stb = frame_stb_q;
   assign shift_cnt = cnt_q;
   assign len_err   = len_err_q;
   assign lit       = ~blank_lvl;

endmodule

// File: tb/tb_led_panel_sink.sv
// Directed + randomised bench for led_panel_sink against a queue-based panel model.
module tb_led_panel_sink;

   localparam int COLS = 32;
   localparam int ROWS = 4;
   localparam int NENT = 2*ROWS;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       sclk_in = 1'b1, red_in = 1'b0, green_in = 1'b0, blue_in = 1'b0;
   logic       latch_in = 1'b0, blank_in = 1'b1, aclk_in = 1'b0, arst_in = 1'b0;
   logic [2:0] rd_row = '0;
   logic [4:0] rd_col = '0;
   logic [2:0] rd_rgb;
   logic       row_stb, frame_stb, len_err, lit;
   logic [1:0] row_idx;
   logic [5:0] shift_cnt;

   int errors = 0;
   int checks = 0;

   // Model: each half-chain is a queue, newest bit at index 0 (= column 0).
   int lo_q[$];
   int hi_q[$];
   int ref_store[NENT][COLS];
   int ref_row, ref_cnt;
   bit ref_len_err;

   led_panel_sink dut (
      .clk(clk), .reset(reset), .sclk_in(sclk_in), .red_in(red_in), .green_in(green_in),
      .blue_in(blue_in), .latch_in(latch_in), .blank_in(blank_in), .aclk_in(aclk_in),
      .arst_in(arst_in), .rd_row(rd_row), .rd_col(rd_col), .rd_rgb(rd_rgb),
      .row_stb(row_stb), .row_idx(row_idx), .frame_stb(frame_stb), .shift_cnt(shift_cnt),
      .len_err(len_err), .lit(lit));

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_reset();
      lo_q.delete();
      hi_q.delete();
      for (int c = 0; c < COLS; c++) begin
         lo_q.push_back(0);
         hi_q.push_back(0);
      end
      for (int r = 0; r < NENT; r++)
         for (int c = 0; c < COLS; c++) ref_store[r][c] = 0;
      ref_row     = 0;
      ref_cnt     = 0;
      ref_len_err = 1'b0;
   endtask

   task automatic set_rgb(input int v);
      logic [2:0] b;
      b = 3'(v);
      {red_in, green_in, blue_in} = b;
   endtask

   // One full sclk period from idle-high: fall shifts hv into the upper half, rise shifts lv into the lower.
   task automatic pair(input int hv, input int lv);
      set_rgb(hv);
      cyc(3);
      sclk_in = 1'b0;
      hi_q.push_front(hv);
      void'(hi_q.pop_back());
      cyc(3);
      set_rgb(lv);
      cyc(3);
      sclk_in = 1'b1;
      lo_q.push_front(lv);
      void'(lo_q.pop_back());
      if (ref_cnt < COLS + 1) ref_cnt++;
      cyc(3);
   endtask

   task automatic rand_pairs(input int n);
      repeat (n) pair(int'($urandom_range(7, 0)), int'($urandom_range(7, 0)));
   endtask

   task automatic aclk_pulse();
      aclk_in = 1'b1;
      cyc(3);
      aclk_in = 1'b0;
      cyc(3);
      if (!arst_in) ref_row = (ref_row == ROWS - 1) ? 0 : ref_row + 1;
   endtask

   task automatic do_latch(input string tag);
      int         seen;
      logic [1:0] idx;
      logic       fr;
      int         exp_frame;
      seen = 0;
      idx  = '0;
      fr   = 1'b0;
      latch_in = 1'b1;
      for (int i = 0; i < 12; i++) begin
         cyc(1);
         if (row_stb === 1'b1) begin
            seen++;
            idx = row_idx;
            fr  = frame_stb;
         end
      end
      latch_in = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cyc(1);
         if (row_stb === 1'b1) seen++;
      end
      for (int c = 0; c < COLS; c++) begin
         ref_store[ref_row][c]        = hi_q[c];
         ref_store[ROWS + ref_row][c] = lo_q[c];
      end
      if (ref_cnt != COLS) ref_len_err = 1'b1;
      ref_cnt   = 0;
      exp_frame = (ref_row == ROWS - 1) ? 1 : 0;
      chk({tag, "_stb_pulses"}, seen, 1);
      chk({tag, "_row_idx"}, idx, ref_row);
      chk({tag, "_frame_stb"}, fr, exp_frame);
      chk({tag, "_len_err"}, len_err, ref_len_err);
      chk({tag, "_shift_cnt"}, shift_cnt, 0);
   endtask

   task automatic check_store(input string tag);
      for (int r = 0; r < NENT; r++)
         for (int c = 0; c < COLS; c++) begin
            rd_row = 3'(r);
            rd_col = 5'(c);
            cyc(1);
            chk($sformatf("%s_r%0d_c%0d", tag, r, c), rd_rgb, ref_store[r][c]);
         end
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_rd_rgb"}, rd_rgb, 0);
      chk({tag, "_row_stb"}, row_stb, 0);
      chk({tag, "_row_idx"}, row_idx, 0);
      chk({tag, "_frame_stb"}, frame_stb, 0);
      chk({tag, "_shift_cnt"}, shift_cnt, 0);
      chk({tag, "_len_err"}, len_err, 0);
      chk({tag, "_lit"}, lit, 0);
   endtask

   initial begin
      int stb_cnt;
      model_reset();
      #1 reset = 1'b0;
      cyc(3);
      check_idle_outputs("por");
      reset = 1'b1;
      cyc(3);

      // Reset mid-shift: partial chains are discarded and no row strobe appears.
      rand_pairs(10);
      chk("mid_shift_cnt", shift_cnt, 10);
      blank_in = 1'b0;
      cyc(4);
      chk("lit_on", lit, 1);
      reset   = 1'b0;
      stb_cnt = 0;
      for (int i = 0; i < 2; i++) begin
         cyc(1);
         if (row_stb !== 1'b0) stb_cnt++;
      end
      model_reset();
      check_idle_outputs("mid_rst");
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cyc(1);
         if (row_stb !== 1'b0) stb_cnt++;
      end
      chk("mid_rst_no_stb", stb_cnt, 0);
      chk("mid_rst_cnt", shift_cnt, 0);
      chk("lit_after_rst", lit, 1);
      blank_in = 1'b1;
      cyc(4);
      chk("lit_off", lit, 0);

      // Uniform row: lower half all 5, upper half all 0, at row 0.
      repeat (COLS) pair(0, 5);
      do_latch("t2");
      check_store("t2");

      // Single lit bit on the first rise lands at column COLS-1.
      for (int i = 0; i < COLS; i++) pair(0, (i == 0) ? 7 : 0);
      do_latch("t3");
      check_store("t3");

      // Row addressing: arst clears the counter and masks aclk; wrap after ROWS-1.
      aclk_pulse();
      arst_in = 1'b1;
      ref_row = 0;
      cyc(4);
      aclk_pulse();
      arst_in = 1'b0;
      cyc(4);
      repeat (3) aclk_pulse();
      rand_pairs(COLS);
      do_latch("t4a");
      chk("t4a_row3", row_idx, 3);
      aclk_pulse();
      rand_pairs(COLS);
      do_latch("t4b");
      chk("t4b_wrap", row_idx, 0);

      // Length errors are sticky; shift_cnt saturates at COLS+1.
      rand_pairs(COLS - 1);
      chk("t5_cnt31", shift_cnt, COLS - 1);
      do_latch("t5a");
      rand_pairs(COLS);
      do_latch("t5b");
      rand_pairs(COLS + 8);
      chk("t5_sat", shift_cnt, COLS + 1);
      do_latch("t5c");

      // Full random frame across all rows, then compare the whole store.
      for (int r = 0; r < ROWS; r++) begin
         rand_pairs(COLS);
         do_latch($sformatf("t6_row%0d", r));
         aclk_pulse();
      end
      check_store("t6");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
